present_round_datapath_ctrl: RTL and testbench
==============================================

Name: present_round_datapath_ctrl

Overview:
- Round controller and 64-bit state datapath for the round-based, area-optimised PRESENT-80 encryption core.
- Sits directly upstream of the round key generator. Drives its round counter, key-load select and freeze signals. Consumes its 64-bit round key each cycle.
- Performs addRoundKey, sLayer and pLayer once per clock, then a final key whitening.
- Exposes valid/ready handshakes for plaintext in and ciphertext out.

Parameters:
- ROUNDS, 31, number of full rounds. Values below 31 are for reduced-round debug only. Range 1..31.
- CNT_W, 5, width of the round counter driven to the key generator.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  plaintext and key valid
- in_ready  out  1  block idle, can accept
- plaintext  in  64  data block. Must be stable only in the accept cycle.
- key_load  out  1  to key generator load select. 1 means capture the external 80-bit key this cycle.
- key_hold  out  1  to key generator freeze. 1 means the key register keeps its value.
- counter  out  CNT_W  round counter to key generator XOR
- key_round  in  64  current round key from key generator, bits [79:16] of its key register
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts
- ciphertext  out  64  registered result

Behaviour:
Reset:
- reset=1 asynchronously forces state IDLE and clears state_reg, ct_reg and counter to 0.
- Reset values of outputs: in_ready=1 (combinational from IDLE), out_valid=0, key_load=0, key_hold=1.

FSM states: IDLE, ROUND, FINAL, OUT.

IDLE:
- Outputs: in_ready=1, key_hold=0, key_load=in_valid.
- On in_valid: state_reg<=plaintext, counter<=1, go to ROUND.
- The key generator captures the external key on the same edge.

ROUND:
- Outputs: key_load=0, key_hold=0.
- Each cycle: state_reg <= pLayer(sLayer(state_reg ^ key_round)). The key generator updates using the current counter.
- If counter==ROUNDS: go to FINAL, counter unchanged. Otherwise counter<=counter+1.

FINAL:
- Outputs: key_hold=1.
- ct_reg <= state_reg ^ key_round (this is K_{ROUNDS+1}). Go to OUT.

OUT:
- Outputs: out_valid=1, key_hold=1, ciphertext=ct_reg.
- On out_ready: counter<=0, go to IDLE.
- ciphertext and out_valid stay stable until the handshake.

Latency:
- Accept edge is cycle 0. out_valid rises after edge ROUNDS+1, i.e. cycle 32 for default ROUNDS.
- Throughput: one block per ROUNDS+2 cycles plus the out stall. No accept while busy (in_ready=0 outside IDLE).

Layer definitions:
- sLayer: the PRESENT S-box {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2} applied to each of the 16 nibbles.
- pLayer: bit i moves to (16*i) mod 63 for i<63; bit 63 stays at 63.

Boundary conditions:
- in_valid is ignored outside IDLE.
- out_ready is ignored outside OUT.
- Reset mid-ROUND aborts the operation, with no out_valid pulse. The key generator is reloaded on the next accept.
- out_ready held high: OUT lasts one cycle, and IDLE can accept on the following cycle.
- counter never exceeds ROUNDS and never wraps.

Optional Feature:
- Macro: PRESENT_ZEROIZE_EN.
- Defined: on the OUT handshake edge, state_reg and ct_reg clear to 0, so ciphertext reads 0 while idle.
- Undefined: both registers retain their last values until the next operation.

Decomposition:
- Package present_pkg holds:
  - constants PRESENT_ROUNDS=31, PRESENT_BLK_W=64, PRESENT_KEY_W=80, PRESENT_CNT_W=5
  - FSM state encoding
  - S-box table
  - pLayer index function
- Sub-module present_player: purely combinational 64-bit permutation.
- Reuse the existing present_sbox as 16 instances for sLayer.

Test Plan:
- pt=0, key=0 -> ciphertext 5579C1387B228445 with out_valid rising exactly 32 cycles after the accept edge.
- pt=0, key=FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049. pt=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B.
- pt=FFFFFFFFFFFFFFFF, key=FFFFFFFFFFFFFFFFFFFF with out_ready held low 10 cycles -> 3333DCD3213210D2, stable throughout; in_ready=0 during the stall; in_valid pulses ignored.
- Back-to-back blocks with out_ready=1 -> second accept in the cycle after OUT; counter sequence 1..31 checked each cycle; key_load high only in accept cycles.
- Assert reset at round 15 -> immediately IDLE, out_valid=0, counter=0; a following pt=0, key=0 still gives 5579C1387B228445.
- With PRESENT_ZEROIZE_EN: ciphertext reads 0 the cycle after the handshake. Without it: value retained.

Source files
------------

// File: rtl/present_pkg.sv
// present_pkg: shared definitions for the round-based PRESENT-80 core.
//   - block/key/counter widths and the default round count
//   - FSM state encoding of the round controller
//   - the 4-bit PRESENT S-box, packed as a 64-bit lookup table
//   - pLayer destination index function
package present_pkg;

  localparam int PRESENT_ROUNDS = 31;
  localparam int PRESENT_BLK_W  = 64;
  localparam int PRESENT_KEY_W  = 80;
  localparam int PRESENT_CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // S(x) is held in bits [4x+3:4x]; S = {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2}.
  localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

  // pLayer: bit i moves to (16*i) mod 63, bit 63 is fixed.
  function automatic int player_idx(input int i);
    return (i == 63) ? 63 : (16 * i) % 63;
  endfunction

endpackage

// File: rtl/present_player.sv
// present_player: PRESENT 64-bit bit permutation (pLayer), pure wiring.
//   data_i : block before permutation
//   data_o : block after permutation
module present_player
  import present_pkg::*;
(
  input  logic [PRESENT_BLK_W-1:0] data_i,
  output logic [PRESENT_BLK_W-1:0] data_o
);

  // The mapping is a bijection, so every output bit is driven exactly once.
  for (genvar gi = 0; gi < PRESENT_BLK_W; gi++) begin : g_bit
    localparam int DST = player_idx(gi);
    assign data_o[DST] = data_i[gi];
  end

endmodule

// File: rtl/present_sbox.sv
// present_sbox: 4-bit PRESENT substitution box, purely combinational.
//   nib_i : input nibble
//   nib_o : substituted nibble
module present_sbox
  import present_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = SBOX_TABLE[{nib_i, 2'b00} +: 4];

endmodule

// File: rtl/present_round_datapath_ctrl.sv
// present_round_datapath_ctrl: round controller and 64-bit state datapath of
// a round-based PRESENT-80 encryption core. One round (addRoundKey, sLayer,
// pLayer) per clock, then a final whitening with the last round key.
//
// Ports:
//   clk, reset             : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready    : plaintext + key handshake (accepted only in IDLE)
//   plaintext              : 64-bit block, sampled in the accept cycle only
//   key_load               : key generator captures the external key this cycle
//   key_hold               : key generator keeps its key register unchanged
//   counter                : round counter fed to the key generator XOR
//   key_round              : current 64-bit round key from the key generator
//   out_valid / out_ready  : ciphertext handshake
//   ciphertext             : registered result, stable until the handshake
//
// Build option: define PRESENT_ZEROIZE_EN to clear the state and result
// registers on the output handshake edge (ciphertext then reads 0 while idle).
module present_round_datapath_ctrl
  import present_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS,
  parameter int CNT_W  = PRESENT_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PRESENT_BLK_W-1:0] plaintext,
  output logic                     key_load,
  output logic                     key_hold,
  output logic [CNT_W-1:0]         counter,
  input  logic [PRESENT_BLK_W-1:0] key_round,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PRESENT_BLK_W-1:0] ciphertext
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS);

  state_e                   state_q, state_d;
  logic [PRESENT_BLK_W-1:0] blk_q, blk_d;
  logic [PRESENT_BLK_W-1:0] ct_q, ct_d;
  logic [CNT_W-1:0]         counter_q, counter_d;

  // Round function datapath.
  logic [PRESENT_BLK_W-1:0] ark;
  logic [PRESENT_BLK_W-1:0] sbox_out;
  logic [PRESENT_BLK_W-1:0] round_out;

  assign ark = blk_q ^ key_round;

  for (genvar gi = 0; gi < PRESENT_BLK_W / 4; gi++) begin : g_sbox
    present_sbox u_sbox (
      .nib_i (ark[4*gi +: 4]),
      .nib_o (sbox_out[4*gi +: 4])
    );
  end

  present_player u_player (
    .data_i (sbox_out),
    .data_o (round_out)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      blk_q     <= '0;
      ct_q      <= '0;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      ct_q      <= ct_d;
      counter_q <= counter_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    ct_d      = ct_q;
    counter_d = counter_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d     = plaintext;
          counter_d = CNT_W'(1);
          state_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        blk_d = round_out;
        // Counter parks at the last round so it never wraps or overshoots.
        if (counter_q == LAST_CNT) begin
          state_d = ST_FINAL;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      ST_FINAL: begin
        // key_round now carries the whitening key K_{ROUNDS+1}.
        ct_d    = ark;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          counter_d = '0;
          state_d   = ST_IDLE;
`ifdef PRESENT_ZEROIZE_EN
          blk_d     = '0;
          ct_d      = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs.
  always_comb begin
    in_ready  = 1'b0;
    key_load  = 1'b0;
    key_hold  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        key_load = in_valid;
      end
      ST_ROUND: ;
      ST_FINAL: key_hold = 1'b1;
      ST_OUT: begin
        out_valid = 1'b1;
        key_hold  = 1'b1;
      end
      default: key_hold = 1'b1;
    endcase
    // Keep the key generator frozen while reset is applied.
    if (reset) begin
      key_load = 1'b0;
      key_hold = 1'b1;
    end
  end

  assign counter    = counter_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_present_round_datapath_ctrl.sv
// Testbench for present_round_datapath_ctrl. Includes a behavioural PRESENT-80
// key generator driven by the DUT's key_load/key_hold/counter outputs.
module tb_present_round_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] plaintext;
  logic        key_load;
  logic        key_hold;
  logic [4:0]  counter;
  logic [63:0] key_round;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ciphertext;

  logic [79:0] ext_key = '0;
  logic [79:0] kreg    = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  present_round_datapath_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key_load   (key_load),
    .key_hold   (key_hold),
    .counter    (counter),
    .key_round  (key_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
  );

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  // PRESENT-80 key schedule step: rotate left 61, S-box top nibble, XOR counter.
  function automatic logic [79:0] kupd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sb(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  always @(posedge clk) begin
    if (key_load)       kreg <= ext_key;
    else if (!key_hold) kreg <= kupd(kreg, counter);
  end
  assign key_round = kreg[79:16];

  typedef struct {
    logic [63:0] pt;
    logic [79:0] key;
    int          stall;
    bit          hold_ready;
    bit          seq;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input vec_t v, input int idx);
    int          cyc;
    logic [63:0] idle_exp;
`ifdef PRESENT_ZEROIZE_EN
    idle_exp = '0;
`else
    idle_exp = v.exp;
`endif
    chk("idle_in_ready", 80'(in_ready), 80'(1));
    plaintext = v.pt;
    ext_key   = v.key;
    in_valid  = 1'b1;
    out_ready = v.hold_ready;
    #1;
    chk("accept_key_load", 80'(key_load), 80'(1));
    step();
    plaintext = 64'hDEAD_BEEF_0BAD_F00D;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (v.seq) chk("counter_seq", 80'(counter), 80'((cyc < 31) ? cyc + 1 : 31));
      in_valid = cyc[0];  // stray requests while busy must be ignored
      #1;
      chk("busy_key_load", 80'(key_load), 80'(0));
      chk("busy_in_ready", 80'(in_ready), 80'(0));
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", 80'(cyc), 80'(32));
    chk("ciphertext", 80'(ciphertext), 80'(v.exp));
    chk("out_key_hold", 80'(key_hold), 80'(1));
    for (int s = 0; s < v.stall; s++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      step();
      chk("stall_out_valid", 80'(out_valid), 80'(1));
      chk("stall_ct", 80'(ciphertext), 80'(v.exp));
      chk("stall_in_ready", 80'(in_ready), 80'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_out_valid", 80'(out_valid), 80'(0));
    chk("post_in_ready", 80'(in_ready), 80'(1));
    chk("post_counter", 80'(counter), 80'(0));
    chk("idle_ct", 80'(ciphertext), 80'(idle_exp));
    out_ready = v.hold_ready;
    $display("block %0d: pt=%h key=%h ct=%h latency=%0d stall=%0d", idx, v.pt, v.key,
             ciphertext, cyc, v.stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h0, 80'h0, 0, 1'b0, 1'b1, 64'h5579C1387B228445};
    vecs[1] = '{64'h0, {80{1'b1}}, 0, 1'b0, 1'b0, 64'hE72C46C0F5945049};
    vecs[2] = '{{64{1'b1}}, 80'h0, 0, 1'b0, 1'b0, 64'hA112FFC72F68417B};
    vecs[3] = '{{64{1'b1}}, {80{1'b1}}, 10, 1'b0, 1'b0, 64'h3333DCD3213210D2};
    vecs[4] = '{64'h0, 80'h0, 0, 1'b1, 1'b1, 64'h5579C1387B228445};
    vecs[5] = '{{64{1'b1}}, {80{1'b1}}, 0, 1'b1, 1'b1, 64'h3333DCD3213210D2};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    #1;
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_key_load", 80'(key_load), 80'(0));
    chk("rst_key_hold", 80'(key_hold), 80'(1));
    chk("rst_counter", 80'(counter), 80'(0));
    chk("rst_ct", 80'(ciphertext), 80'(0));
    step();
    reset = 1'b0;
    #1;
    chk("idle_key_hold", 80'(key_hold), 80'(0));

    // Table-driven blocks; entries 3->4->5 run back to back.
    for (int i = 0; i < 6; i++) run_block(vecs[i], i);

    // Reset in the middle of round 15 aborts the block.
    plaintext = {64{1'b1}};
    ext_key   = {80{1'b1}};
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("pre_abort_counter", 80'(counter), 80'(15));
    reset = 1'b1;
    #1;
    chk("abort_out_valid", 80'(out_valid), 80'(0));
    chk("abort_in_ready", 80'(in_ready), 80'(1));
    chk("abort_counter", 80'(counter), 80'(0));
    chk("abort_key_hold", 80'(key_hold), 80'(1));
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_quiet_out_valid", 80'(out_valid), 80'(0));
    end
    $display("abort at round 15 done");
    run_block(vecs[0], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
